// File: rtl/mult_share_rr.sv
// -----------------------------------------------------------------------------
// mult_share_rr
//
// Round-robin scheduler that time-shares one signed N x M multiplier between
// R requesters. A winning request's operands are latched and held for LAT
// settle cycles so the ripple-carry array can resolve. The product is then
// registered and returned, tagged with the index of the requester that owns it.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   [R]      per-requester operand valid
//   req_ready   [R]      per-requester accept (one-hot or zero, IDLE only)
//   req_a       [R*N]    flattened A operands, requester i at [i*N +: N]
//   req_b       [R*M]    flattened B operands, requester i at [i*M +: M]
//   resp_valid           product valid
//   resp_ready           consumer accepts product
//   resp_id     [IDW]    owner of the product
//   resp_prod   [N+M]    signed product A*B
//   busy                 high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mult_share_rr #(
  parameter  int N   = 4,
  parameter  int M   = 5,
  parameter  int R   = 2,
  parameter  int LAT = 2,
  localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*M-1:0]   req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [N+M-1:0]   resp_prod,
  output logic             busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int PW = N + M;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [N-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            vld_q, vld_d;

  // ---------------------------------------------------------------------------
  // Per-requester operand views
  // ---------------------------------------------------------------------------
  logic [N-1:0] a_arr [R];
  logic [M-1:0] b_arr [R];

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_ops
      assign a_arr[gi] = req_a[gi*N +: N];
      assign b_arr[gi] = req_b[gi*M +: M];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first valid requester from ptr upward, wrapping at R
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] cand;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;

  always_comb begin
    cand        = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < R; k++) begin
      cand = IDW'((int'(ptr_q) + k) % R);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gated with rst_n so no accept strobe escapes while reset is held.
  logic [R-1:0] grant_onehot;
  assign grant_onehot = {{(R-1){1'b0}}, 1'b1} << grant_idx;
  assign req_ready    = (rst_n && state_q == IDLE && grant_found) ? grant_onehot : '0;

  // ---------------------------------------------------------------------------
  // Sign-magnitude multiplier. The N-bit unsigned magnitude of -2^(N-1) is
  // exactly 2^(N-1), so no extra bit is needed on either operand. The largest
  // magnitude product, 2^(N+M-2), fits in N+M bits with room for the sign.
  // ---------------------------------------------------------------------------
  logic [N-1:0]  mag_a;
  logic [M-1:0]  mag_b;
  logic          prod_neg;
  logic [PW-1:0] pp [M];
  logic [PW-1:0] mag_p;
  logic [PW-1:0] prod_c;

  assign mag_a    = a_q[N-1] ? (~a_q + N'(1)) : a_q;
  assign mag_b    = b_q[M-1] ? (~b_q + M'(1)) : b_q;
  assign prod_neg = a_q[N-1] ^ b_q[M-1];

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_pp
      assign pp[gi] = mag_b[gi] ? (PW'(mag_a) << gi) : '0;
    end
  endgenerate

  always_comb begin
    mag_p = '0;
    for (int k = 0; k < M; k++) begin
      mag_p = mag_p + pp[k];
    end
  end

  assign prod_c = prod_neg ? (~mag_p + PW'(1)) : mag_p;

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          id_d    = grant_idx;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Operands have been stable for LAT cycles once cnt reaches LAT-1.
        if (cnt_q == CW'(LAT - 1)) begin
          prod_d  = prod_c;
          vld_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          vld_d   = 1'b0;
          ptr_d   = (id_q == IDW'(R - 1)) ? '0 : id_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      vld_q   <= vld_d;
    end
  end

  assign resp_valid = vld_q;
  assign resp_id    = id_q;
  assign resp_prod  = prod_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_rr.sv
// -----------------------------------------------------------------------------
// tb_mult_share_rr
//
// Self-checking bench for mult_share_rr at N=4, M=5, R=2, LAT=2. A vector
// table covers single operations and signed corners. Hand-written sequences
// cover contention, backpressure, reset during CALC and a full operand sweep.
// -----------------------------------------------------------------------------
module tb_mult_share_rr;

  localparam int N   = 4;
  localparam int M   = 5;
  localparam int R   = 2;
  localparam int LAT = 2;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*M-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [0:0]     resp_id;
  logic [N+M-1:0] resp_prod;
  logic           busy;

  int errors = 0;
  int checks = 0;

  mult_share_rr #(.N(N), .M(M), .R(R), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transaction from a single requester with resp_ready high.
  task automatic run_op(input int id, input logic [3:0] a, input logic [4:0] b,
                        input logic [8:0] exp_p, input string tag);
    int lat;
    @(negedge clk);
    req_a[id*N +: N] = a;
    req_b[id*M +: M] = b;
    req_valid        = '0;
    req_valid[id]    = 1'b1;
    #1;
    check({tag, " ready"}, 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check({tag, " latency"}, lat, LAT + 1);
    check({tag, " prod"}, 32'(resp_prod), 32'(exp_p));
    check({tag, " id"}, 32'(resp_id), id);
    $display("op %s: id=%0d a=%h b=%h prod=%h lat=%0d", tag, id, a, b, resp_prod, lat);
    @(negedge clk);
    check({tag, " idle after"}, {30'd0, busy, resp_valid}, 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [4:0] b;
    logic [8:0] exp_p;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    logic [3:0]  sa;
    logic [4:0]  sb;
    logic [31:0] sp;

    vecs[0] = '{0, 4'hD, 5'h07, 9'h1EB};   // -3 * 7   = -21
    vecs[1] = '{0, 4'h8, 5'h10, 9'h080};   // -8 * -16 = +128
    vecs[2] = '{1, 4'h5, 5'h1F, 9'h1FB};   //  5 * -1  = -5
    vecs[3] = '{1, 4'h7, 5'h0F, 9'h069};   //  7 * 15  = 105
    vecs[4] = '{0, 4'h8, 5'h0F, 9'h188};   // -8 * 15  = -120
    vecs[5] = '{1, 4'h7, 5'h10, 9'h190};   //  7 * -16 = -112
    vecs[6] = '{0, 4'h0, 5'h1F, 9'h000};   //  0 * -1  = 0
    vecs[7] = '{1, 4'hF, 5'h1F, 9'h001};   // -1 * -1  = 1

    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset outputs", {resp_valid, busy, resp_id, resp_prod}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- contention ----------------
    req_a = {4'hE, 4'h3};           // req1: -2, req0: 3
    req_b = {5'd5, 5'd2};           // req1: 5,  req0: 2
    @(negedge clk);
    req_valid = 2'b11;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("contention ready", 32'(req_ready),
            (c % 4 == 0) ? 32'(1 << ((c / 4) % 2)) : 32'd0);
      if (c % 4 == 3) begin
        check("contention valid", 32'(resp_valid), 32'd1);
        check("contention id", 32'(resp_id), 32'((c / 4) % 2));
        check("contention prod", 32'(resp_prod), ((c / 4) % 2 == 0) ? 32'h006 : 32'h1F6);
        $display("contention cycle %0d: id=%0d prod=%h", c, resp_id, resp_prod);
      end else begin
        check("contention novalid", 32'(resp_valid), 32'd0);
      end
    end
    req_valid = '0;
    lat = 0;
    while (busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("contention drain", 32'(busy), 32'd0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_p, $sformatf("vec%0d", i));
    end

    // ---------------- backpressure ----------------
    resp_ready = 1'b0;
    @(negedge clk);
    req_a[0 +: N] = 4'h2;
    req_b[0 +: M] = 5'h03;
    req_valid     = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 2'b10;              // competing request while busy
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check("bp latency", lat, LAT + 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check("bp hold", {resp_valid, busy, 21'd0, resp_id, resp_prod},
            {1'b1, 1'b1, 21'd0, 1'b0, 9'h006});
      check("bp ready", 32'(req_ready), 32'd0);
      $display("backpressure cycle %0d: prod=%h id=%0d busy=%0d", c, resp_prod, resp_id, busy);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp release", {30'd0, resp_valid, busy}, 32'd0);
    check("bp regrant", 32'(req_ready), 32'b10);
    req_valid = '0;

    // ---------------- reset mid-CALC ----------------
    @(negedge clk);
    req_a[1*N +: N] = 4'h1;
    req_b[1*M +: M] = 5'h01;
    req_valid       = 2'b10;
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst mid outputs", {resp_valid, busy, resp_id, resp_prod}, 32'd0);
    check("rst mid ready", 32'(req_ready), 32'd0);
    $display("reset mid-CALC: valid=%0d busy=%0d id=%0d prod=%h", resp_valid, busy, resp_id, resp_prod);
    @(negedge clk);
    req_a[0 +: N] = 4'h3;
    req_b[0 +: M] = 5'h1D;          // 3 * -3 = -9
    rst_n = 1'b1;
    #1;
    check("rst first grant", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (resp_valid && resp_id != 1'b0) check("rst stale resp", 32'(resp_id), 32'd0);
    end while (!resp_valid && lat < 20);
    check("rst new latency", lat, LAT + 1);
    check("rst new prod", 32'(resp_prod), 32'h1F7);
    check("rst new id", 32'(resp_id), 32'd0);
    @(negedge clk);

    // ---------------- full sweep from requester 1 ----------------
    for (int i = 0; i < 512; i++) begin
      sa = 4'(i);
      sb = 5'(i >> 4);
      sp = 32'(int'($signed(sa)) * int'($signed(sb)));
      run_op(1, sa, sb, sp[8:0], "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_share_rr.md
# mult_share_rr

Round-robin scheduler that shares one signed N×M multiplier datapath between R requesters. Each requester presents signed operands with a valid/ready handshake. The block arbitrates, latches the winning operands, holds them stable for a programmable settle time sized to the ripple-carry multiplier's critical path, then returns the signed product tagged with the requester index. It sits between client blocks (filters, MAC sequencers) and the shared combinational multiplier array.

## Interface
- N, default 4: width of operand A, two's complement.
- M, default 5: width of operand B, two's complement.
- R, default 2: number of requesters, 2..8.
- LAT, default 2: settle cycles the latched operands are held before the product is registered; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  R  per-requester operand-valid.
- req_ready  out  R  per-requester accept strobe; at most one bit high.
- req_a  in  R*N  flattened A operands; requester i uses bits [i*N +: N].
- req_b  in  R*M  flattened B operands; requester i uses bits [i*M +: M].
- resp_valid  out  1  product valid.
- resp_ready  in  1  consumer accepts product.
- resp_id  out  clog2(R), minimum 1  index of the requester owning the product.
- resp_prod  out  N+M  signed product A*B, two's complement.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searched from the priority pointer ptr upward, mod R.
  - req_ready is combinational: one-hot on the winner, and only in IDLE.
  - On a handshake (req_valid[i] & req_ready[i]), latch A_i, B_i and i, clear the settle counter, and go to CALC.
- CALC:
  - Latched operands drive the multiplier; the counter increments each cycle.
  - When the counter reaches LAT-1, register the product into resp_prod, set resp_valid, and go to RESP.
- RESP:
  - resp_valid, resp_id and resp_prod are held stable until resp_ready=1.
  - On that cycle, clear resp_valid, set ptr = (resp_id+1) mod R, and go to IDLE.
- Arithmetic:
  - Full-precision signed product; N+M bits never overflow.
  - The most-negative × most-negative case must be exact: −2^(N−1) × −2^(M−1) = +2^(N+M−2).
  - Sign handling is magnitude multiply plus conditional two's complement on sign(A) XOR sign(B).
  - The magnitude path is N bits for A and M bits for B, and must not truncate the most-negative magnitude.
- No new request is accepted while busy. req_valid changes from non-granted requesters are ignored.
- A requester that deasserts req_valid in IDLE before its handshake loses nothing; arbitration simply re-evaluates.

## Timing
- Reset (asynchronous, rst_n=0) forces the following, regardless of state; any in-flight operation is discarded and no response is issued for it:
  - state = IDLE, ptr = 0;
  - resp_valid = 0, resp_prod = 0, resp_id = 0;
  - busy = 0, req_ready = 0 while held in reset.
- Handshake in cycle t gives:
  - CALC in cycles t+1 .. t+LAT;
  - resp_valid = 1 from cycle t+LAT+1.
- Minimum issue interval is LAT+2 cycles, i.e. 4 at the default LAT=2, with resp_ready tied high.
- The RESP→IDLE cycle uses the updated ptr, so a requester that held req_valid high is re-granted only if no other requester is valid.
- Simultaneous req_valid from all R requesters gives grants in strict rotation starting at ptr.
- resp_ready high while resp_valid=0 has no effect.

## Test plan
- Single op: N=4, M=5, LAT=2. Requester 0 sends A=4'hD (−3), B=5'h07 (7) → resp_valid in cycle t+3, resp_prod=9'h1EB (−21), resp_id=0.
- Corner: A=4'h8 (−8), B=5'h10 (−16) → 9'h080 (+128). Then A=4'h5, B=5'h1F (−1) → 9'h1FB (−5).
- Contention: both requesters valid continuously, resp_ready=1 → grants alternate 0,1,0,1; each req_ready pulse is one cycle; issue interval is 4 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → the product and id stay stable, busy=1, req_ready=0 throughout. Release → IDLE next cycle.
- Reset mid-CALC: assert rst_n=0 one cycle after a handshake → all outputs are 0 immediately. After release, no stale response appears, and a new request from requester 0 is granted first.
- Sweep: all 2^9 operand pairs from requester 1 → every resp_prod equals the signed reference product, and resp_id=1.
